// File: rtl/ap_ctrl_txn_recorder.sv
// Transaction recorder for one ap_ctrl_hs / ap_ctrl_chain block: timestamps start->ready,
// start->done and done-stall, and queues one record per transaction into a FWFT FIFO.
module ap_ctrl_txn_recorder #(
  parameter int CNT_W = 32,
  parameter int TXN_W = 16,
  parameter int DEPTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   ap_start,
  input  logic                   ap_ready,
  input  logic                   ap_done,
  input  logic                   ap_continue,
  input  logic                   finish,
  output logic                   rec_valid,
  input  logic                   rec_ready,
  output logic [TXN_W-1:0]       rec_txn,
  output logic [CNT_W-1:0]       rec_latency,
  output logic [CNT_W-1:0]       rec_ready_lat,
  output logic [CNT_W-1:0]       rec_stall,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   overflow,
  output logic                   drained
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

  typedef struct packed {
    logic [TXN_W-1:0] txn;
    logic [CNT_W-1:0] lat;
    logic [CNT_W-1:0] rlat;
    logic [CNT_W-1:0] stall;
  } rec_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] lat_q, lat_d, rlat_q, rlat_d, stall_q, stall_d;
  logic             seen_q, seen_d;
  logic [TXN_W-1:0] txn_q, txn_d;
  logic             wr_en;
  rec_t             wr_rec;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    rlat_d  = rlat_q;
    stall_d = stall_q;
    seen_d  = seen_q;
    wr_en   = 1'b0;
    wr_rec  = '{txn: txn_q, lat: lat_q, rlat: (seen_q ? rlat_q : lat_q), stall: stall_q};
    unique case (state_q)
      IDLE: begin
        if (ap_start && enable) begin
          lat_d   = '0;
          rlat_d  = '0;
          stall_d = '0;
          seen_d  = ap_ready;
          if (ap_done && ap_continue) begin
            wr_en  = 1'b1;
            wr_rec = '{txn: txn_q, lat: '0, rlat: '0, stall: '0};
          end else if (ap_done) begin
            stall_d = CNT_W'(1);
            state_d = HOLD;
          end else begin
            lat_d   = CNT_W'(1);
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (ap_ready && !seen_q) begin
          seen_d = 1'b1;
          rlat_d = lat_q;
        end
        if (ap_done && ap_continue) begin
          wr_en   = 1'b1;
          state_d = IDLE;
        end else if (ap_done) begin
          // The done cycle itself is the first stalled cycle; latency stays frozen from here.
          stall_d = CNT_W'(1);
          state_d = HOLD;
        end else begin
          lat_d = sat_inc(lat_q);
        end
      end
      HOLD: begin
        if (ap_continue) begin
          wr_en   = 1'b1;
          state_d = IDLE;
        end else begin
          stall_d = sat_inc(stall_q);
        end
      end
      default: state_d = IDLE;
    endcase
    txn_d = wr_en ? txn_q + TXN_W'(1) : txn_q;
  end

  // Record FIFO
  rec_t             mem [DEPTH];
  rec_t             last_q, last_d;
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             ovf_q, ovf_d, drained_q, drained_d;
  logic             rd_en, fifo_wr, drop, full;
  rec_t             head;

  assign full = (level_q == LW'(DEPTH));
  assign head = mem[rptr_q];

  always_comb begin
    rd_en     = (level_q != '0) && rec_ready;
    fifo_wr   = wr_en && (!full || rd_en);
    drop      = wr_en && full && !rd_en;
    wptr_d    = fifo_wr ? wptr_q + AW'(1) : wptr_q;
    rptr_d    = rd_en ? rptr_q + AW'(1) : rptr_q;
    last_d    = rd_en ? head : last_q;
    level_d   = level_q;
    if (fifo_wr && !rd_en) level_d = level_q + LW'(1);
    else if (!fifo_wr && rd_en) level_d = level_q - LW'(1);
    drop_d    = drop ? sat_inc(drop_q) : drop_q;
    ovf_d     = ovf_q | drop;
    drained_d = finish && (state_q == IDLE) && (level_q == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      rlat_q    <= '0;
      stall_q   <= '0;
      seen_q    <= 1'b0;
      txn_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      last_q    <= '0;
      drop_q    <= '0;
      ovf_q     <= 1'b0;
      drained_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      rlat_q    <= rlat_d;
      stall_q   <= stall_d;
      seen_q    <= seen_d;
      txn_q     <= txn_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      last_q    <= last_d;
      drop_q    <= drop_d;
      ovf_q     <= ovf_d;
      drained_q <= drained_d;
    end
  end

  // NOTE: storage is not reset; only slots covered by level are ever observed, and the
  // reset-time record outputs come from last_q.
  always_ff @(posedge clock) begin
    if (fifo_wr) mem[wptr_q] <= wr_rec;
  end

  rec_t out_rec;
  assign out_rec       = (level_q != '0) ? head : last_q;
  assign rec_valid     = (level_q != '0);
  assign rec_txn       = out_rec.txn;
  assign rec_latency   = out_rec.lat;
  assign rec_ready_lat = out_rec.rlat;
  assign rec_stall     = out_rec.stall;
  assign busy          = (state_q != IDLE);
  assign fifo_level    = level_q;
  assign drop_cnt      = drop_q;
  assign overflow      = ovf_q;
  assign drained       = drained_q;
endmodule

// File: tb/tb_ap_ctrl_txn_recorder.sv
// Directed bench for ap_ctrl_txn_recorder: a wide-id and a 2-bit-id instance (both DEPTH=4)
// share stimulus; expected records go into per-instance queues checked by negedge monitors.
module tb_ap_ctrl_txn_recorder;
  logic clock = 1'b0;
  logic reset, enable, ap_start, ap_ready, ap_done, ap_continue, finish, rec_ready;

  logic        rec_valid_a, busy_a, overflow_a, drained_a;
  logic [15:0] rec_txn_a;
  logic [31:0] rec_latency_a, rec_ready_lat_a, rec_stall_a, drop_cnt_a;
  logic [2:0]  fifo_level_a;

  logic        rec_valid_b, busy_b, overflow_b, drained_b;
  logic [1:0]  rec_txn_b;
  logic [31:0] rec_latency_b, rec_ready_lat_b, rec_stall_b, drop_cnt_b;
  logic [2:0]  fifo_level_b;

  ap_ctrl_txn_recorder #(.CNT_W(32), .TXN_W(16), .DEPTH(4)) dut_a (
    .clock(clock), .reset(reset), .enable(enable), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish), .rec_valid(rec_valid_a),
    .rec_ready(rec_ready), .rec_txn(rec_txn_a), .rec_latency(rec_latency_a),
    .rec_ready_lat(rec_ready_lat_a), .rec_stall(rec_stall_a), .busy(busy_a),
    .fifo_level(fifo_level_a), .drop_cnt(drop_cnt_a), .overflow(overflow_a), .drained(drained_a));

  ap_ctrl_txn_recorder #(.CNT_W(32), .TXN_W(2), .DEPTH(4)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .ap_start(ap_start), .ap_ready(ap_ready),
    .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish), .rec_valid(rec_valid_b),
    .rec_ready(rec_ready), .rec_txn(rec_txn_b), .rec_latency(rec_latency_b),
    .rec_ready_lat(rec_ready_lat_b), .rec_stall(rec_stall_b), .busy(busy_b),
    .fifo_level(fifo_level_b), .drop_cnt(drop_cnt_b), .overflow(overflow_b), .drained(drained_b));

  always #5 clock = ~clock;

  typedef struct {
    int txn;
    int lat;
    int rlat;
    int stall;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_txn  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
    else n_pass++;
  endtask

  always @(negedge clock) begin
    if (reset && rec_valid_a && rec_ready) begin
      if (qa.size() == 0) begin
        n_checks++;
        $display("FAIL a_unexpected_record: got txn %0d expected none", rec_txn_a);
      end else begin
        ea = qa.pop_front();
        check("a_txn", rec_txn_a, ea.txn);
        check("a_latency", rec_latency_a, ea.lat);
        check("a_ready_lat", rec_ready_lat_a, ea.rlat);
        check("a_stall", rec_stall_a, ea.stall);
      end
    end
  end

  always @(negedge clock) begin
    if (reset && rec_valid_b && rec_ready) begin
      if (qb.size() == 0) begin
        n_checks++;
        $display("FAIL b_unexpected_record: got txn %0d expected none", rec_txn_b);
      end else begin
        eb = qb.pop_front();
        check("b_txn", rec_txn_b, eb.txn);
        check("b_latency", rec_latency_b, eb.lat);
        check("b_ready_lat", rec_ready_lat_b, eb.rlat);
        check("b_stall", rec_stall_b, eb.stall);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drives one transaction: start in cycle 0, ap_ready in cycle rdy (rdy<0: never),
  // done from cycle lat, continue low for `stall` cycles starting at the done cycle.
  task automatic txn(input int lat, input int rdy, input int stall, input bit keep_start,
                     input bit drop_en, input bit push);
    exp_t e;
    e.lat   = lat;
    e.rlat  = (rdy < 0) ? lat : rdy;
    e.stall = stall;
    for (int k = 0; k <= lat + stall; k++) begin
      ap_start    = (k == 0) || (k <= rdy) || keep_start;
      ap_ready    = (k == rdy);
      ap_done     = (k >= lat);
      ap_continue = !(k >= lat && k < lat + stall);
      if (drop_en && k >= 1) enable = 1'b0;
      check("busy", busy_a, k > 0);
      if (k == lat + stall) begin
        if (push) begin
          e.txn = exp_txn;
          qa.push_back(e);
          e.txn = exp_txn % 4;
          qb.push_back(e);
        end
        exp_txn++;
      end
      step();
    end
    ap_start    = keep_start;
    ap_ready    = 1'b0;
    ap_done     = 1'b0;
    ap_continue = 1'b1;
    enable      = 1'b1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0 || rec_valid_a || rec_valid_b) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d/%0d records pending expected 0", qa.size(), qb.size());
    end
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    #1;
    check("rst_rec_valid", rec_valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_fifo_level", fifo_level_a, 0);
    check("rst_drop_cnt", drop_cnt_a, 0);
    check("rst_overflow", overflow_a, 0);
    check("rst_drained", drained_a, 0);
    check("rst_rec_txn", rec_txn_a, 0);
    check("rst_rec_latency", rec_latency_a, 0);
    check("rst_rec_ready_lat", rec_ready_lat_a, 0);
    check("rst_rec_stall", rec_stall_a, 0);
    check("rst_b_level", fifo_level_b, 0);
    step();
    reset = 1'b1;
    step();
    exp_txn = 0;
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0;
    ap_continue = 1'b1; finish = 1'b0; rec_ready = 1'b1;
    step();
    reset_dut();

    // ap_ctrl_hs: ready at latency 4, done at latency 7
    txn(7, 4, 0, 1'b0, 1'b0, 1'b1);
    check("busy_after_hs", busy_a, 0);
    // Start, ready and done in the same IDLE cycle
    txn(0, 0, 0, 1'b0, 1'b0, 1'b1);
    check("busy_after_instant", busy_a, 0);
    // ap_ctrl_chain stall of 3, then a back-to-back start with no ap_ready
    txn(5, 2, 3, 1'b1, 1'b0, 1'b1);
    txn(3, -1, 0, 1'b0, 1'b0, 1'b1);
    wait_drain();

    // Overflow: fresh ids, consumer stalled, six transactions into a depth-4 FIFO
    reset_dut();
    rec_ready = 1'b0;
    for (int i = 0; i < 6; i++) txn(2, 1, 0, 1'b0, 1'b0, i < 4);
    step();
    check("ovf_level", fifo_level_a, 4);
    check("ovf_drop_cnt", drop_cnt_a, 2);
    check("ovf_overflow", overflow_a, 1);
    check("ovf_b_drop_cnt", drop_cnt_b, 2);
    rec_ready = 1'b1;
    wait_drain();
    check("ovf_level_empty", fifo_level_a, 0);
    check("ovf_sticky", overflow_a, 1);
    txn(2, 1, 0, 1'b0, 1'b0, 1'b1);
    wait_drain();

    // Reset in the middle of RUN discards the transaction
    ap_start = 1'b1;
    step();
    ap_start = 1'b0;
    step();
    check("busy_before_reset", busy_a, 1);
    reset_dut();
    // Enable dropped mid-flight: transaction still completes with missing-ready latency
    txn(4, -1, 0, 1'b0, 1'b1, 1'b1);
    txn(1, 0, 0, 1'b0, 1'b0, 1'b1);
    txn(2, 1, 0, 1'b0, 1'b0, 1'b1);
    txn(3, 3, 0, 1'b0, 1'b0, 1'b1);
    txn(6, 2, 2, 1'b0, 1'b0, 1'b1);
    wait_drain();

    // enable=0 blocks even an instant transaction
    enable = 1'b0; ap_start = 1'b1; ap_ready = 1'b1; ap_done = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("disabled_busy", busy_a, 0);
      check("disabled_level", fifo_level_a, 0);
    end
    enable = 1'b1; ap_start = 1'b0; ap_ready = 1'b0; ap_done = 1'b0;
    step();

    check("drained_before_finish", drained_a, 0);
    finish = 1'b1;
    step();
    check("drained_a", drained_a, 1);
    check("drained_b", drained_b, 1);
    finish = 1'b0;
    step();
    check("drained_cleared", drained_a, 0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ap_ctrl_txn_recorder.md
Name: ap_ctrl_txn_recorder

Overview:
- Synthesizable per-module transaction recorder for one non-dataflow HLS block using the ap_ctrl_hs/ap_ctrl_chain handshake, e.g. the cpu top or one of its pipelined loop sub-blocks.
- Sits directly upstream of the simulation dataflow monitor / CSV dump path.
- Watches ap_start, ap_ready, ap_done and ap_continue, and timestamps each transaction.
- Pushes one record per completed transaction into an internal FIFO, which is drained through a valid/ready port.

Parameters:
- CNT_W, 32, width of the latency counters; counters saturate at all-ones.
- TXN_W, 16, width of the transaction id; wraps modulo 2^TXN_W.
- DEPTH, 16, record FIFO depth; power of two, minimum 2.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  permits new transactions to be accepted.
- ap_start  in  1  observed start.
- ap_ready  in  1  observed ready.
- ap_done  in  1  observed done.
- ap_continue  in  1  observed continue; tie to 1 for ap_ctrl_hs.
- finish  in  1  end-of-test request.
- rec_valid  out  1  FIFO head valid (first-word fall-through).
- rec_ready  in  1  consumer accepts head.
- rec_txn  out  TXN_W  transaction id.
- rec_latency  out  CNT_W  cycles from start to done.
- rec_ready_lat  out  CNT_W  cycles from start to first ap_ready.
- rec_stall  out  CNT_W  cycles done was held with ap_continue=0.
- busy  out  1  transaction in flight.
- fifo_level  out  $clog2(DEPTH)+1  occupancy.
- drop_cnt  out  CNT_W  records lost to a full FIFO, saturating.
- overflow  out  1  sticky; set on the first drop.
- drained  out  1  finish seen, state is IDLE, and FIFO is empty.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; all counters, FIFO pointers and the txn id are 0.
  - Outputs: rec_valid=0, busy=0, fifo_level=0, drop_cnt=0, overflow=0, drained=0; rec_* data=0.
  - Any in-flight transaction is discarded; no record is written.
- FSM states: IDLE, RUN, HOLD.
- IDLE:
  - Start is accepted when ap_start=1 and enable=1. This is cycle T0; the latency counter loads 0.
  - If ap_ready=1 in T0, ready_lat=0.
  - If ap_done=1 and ap_continue=1 in T0: write record {id, 0, 0, 0} and stay in IDLE.
  - If ap_done=1 and ap_continue=0 in T0: go to HOLD.
  - Otherwise go to RUN.
- RUN:
  - The latency counter increments every cycle.
  - On the first ap_ready=1, ready_lat captures the current latency count; later ap_ready pulses are ignored.
  - ap_done=1 with ap_continue=1: write record, go to IDLE.
  - ap_done=1 with ap_continue=0: latency freezes, go to HOLD.
- HOLD:
  - The stall counter increments each cycle while ap_continue=0.
  - When ap_continue=1: write record, go to IDLE.
- Restart timing:
  - ap_start is not sampled in the cycle a record is written.
  - A back-to-back start is accepted at the earliest in the following cycle.
- Missing ready: if no ap_ready was seen before done, ready_lat equals latency.
- Txn id: increments after each record write, whether or not the record was dropped; wraps to 0.
- enable=0: no new start is accepted; an in-flight transaction completes normally.
- busy: 1 in RUN and HOLD; 0 in IDLE.
- Record FIFO:
  - Write: registered; the record is visible at rec_valid one cycle after the write cycle.
  - Read: occurs when rec_valid && rec_ready.
  - Full, write without read: drop the record, increment drop_cnt, set overflow.
  - Full, write with read in the same cycle: the write is accepted; level is unchanged.
  - Empty: rec_valid=0; rec_* data is held at the last value.
- drained: registered; 1 while finish=1, state=IDLE and fifo_level=0. It deasserts when finish=0.

Test Plan:
- ap_ctrl_hs, start at cycle 10 held until ready at cycle 14, done at cycle 17, continue=1 -> one record {txn=0, latency=7, ready_lat=4, stall=0}; busy high for cycles 11-17.
- ap_start, ap_ready and ap_done all high in one cycle from IDLE -> record {0, 0, 0, 0}; busy never asserts.
- ap_ctrl_chain: done at latency 5, ap_continue low for 3 cycles -> record {latency=5, stall=3}; the next start is accepted only after the record write cycle.
- DEPTH=4, rec_ready=0, 6 transactions -> fifo_level=4, drop_cnt=2, overflow=1. Then rec_ready=1 -> txn ids 0,1,2,3 read out in order; the next record carries txn 6.
- Assert reset mid-RUN, release, then run one transaction -> no partial record; the new record has txn=0 and correct latency.
- TXN_W=2, 5 transactions -> txn ids 0,1,2,3,0. With enable=0 and ap_start=1 -> no record, busy=0. finish=1 after draining -> drained=1.
